// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution loop-nest scheduler.
// Holds the FSM state enum and the counter width function.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  // Bits needed to hold 0..max_v; a constant-zero counter still gets one bit.
  function automatic int cnn_w(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/cnn_sched_ctr.sv
// One level of the loop nest: counts 0..max_p-1 and flags the wrapping increment
// so the next level outward can advance in the same cycle.
module cnn_sched_ctr
  import cnn_pkg::*;
#(
  parameter int  max_p = 2,
  localparam int W     = cnn_w(max_p - 1)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] it_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(max_p - 1);

  assign wrap_o = en_i && (it_o == LAST);

  // NOTE: sequential state uses non-blocking assignments so every level samples
  // the pre-edge values of its neighbours, like real flops.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      it_o <= '0;
    end else if (clr_i) begin
      it_o <= '0;
    end else if (en_i) begin
      it_o <= wrap_o ? '0 : it_o + 1'b1;
    end
  end

endmodule

// File: rtl/cnn_loop_sched.sv
// Loop-nest sequencer for the tiled convolution datapath: walks to, row, col, ti,
// i, j (innermost j) and issues one step per valid/ready handshake.
module cnn_loop_sched
  import cnn_pkg::*;
#(
  parameter int  N_p  = 4,
  parameter int  M_p  = 4,
  parameter int  K_p  = 2,
  parameter int  R_p  = 16,
  parameter int  C_p  = 16,
  parameter int  S_p  = 1,
  parameter int  Tn_p = 2,
  parameter int  Tm_p = 2,
  localparam int TOW  = cnn_w(M_p / Tm_p - 1),
  localparam int TIW  = cnn_w(N_p / Tn_p - 1),
  localparam int RW   = cnn_w(R_p - 1),
  localparam int CW   = cnn_w(C_p - 1),
  localparam int KW   = cnn_w(K_p - 1),
  localparam int IRW  = cnn_w((R_p - 1) * S_p + K_p - 1),
  localparam int ICW  = cnn_w((C_p - 1) * S_p + K_p - 1)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic           abort_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           step_v_o,
  input  logic           step_ready_i,
  output logic [TOW-1:0] to_o,
  output logic [TIW-1:0] ti_o,
  output logic [RW-1:0]  row_o,
  output logic [CW-1:0]  col_o,
  output logic [KW-1:0]  i_o,
  output logic [KW-1:0]  j_o,
  output logic [IRW-1:0] in_row_o,
  output logic [ICW-1:0] in_col_o,
  output logic           first_o,
  output logic           last_o
);

  if (N_p % Tn_p != 0) begin : g_bad_tn
    $error("cnn_loop_sched: Tn_p must divide N_p");
  end
  if (M_p % Tm_p != 0) begin : g_bad_tm
    $error("cnn_loop_sched: Tm_p must divide M_p");
  end

  localparam logic [TIW-1:0] TI_LAST = TIW'(N_p / Tn_p - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(K_p - 1);

  sched_state_t state;
  logic hs;
  logic j_wrap, i_wrap, ti_wrap, col_wrap, row_wrap, to_wrap;

  // Abort beats a same-cycle handshake, so the counters never advance under it.
  assign hs = step_v_o && step_ready_i && !abort_i;

  cnn_sched_ctr #(.max_p(K_p)) u_j (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(hs),       .it_o(j_o),   .wrap_o(j_wrap));
  cnn_sched_ctr #(.max_p(K_p)) u_i (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(j_wrap),   .it_o(i_o),   .wrap_o(i_wrap));
  cnn_sched_ctr #(.max_p(N_p / Tn_p)) u_ti (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(i_wrap),   .it_o(ti_o),  .wrap_o(ti_wrap));
  cnn_sched_ctr #(.max_p(C_p)) u_col (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(ti_wrap),  .it_o(col_o), .wrap_o(col_wrap));
  cnn_sched_ctr #(.max_p(R_p)) u_row (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(col_wrap), .it_o(row_o), .wrap_o(row_wrap));
  cnn_sched_ctr #(.max_p(M_p / Tm_p)) u_to (
    .clk_i, .reset_i, .clr_i(abort_i), .en_i(row_wrap), .it_o(to_o),  .wrap_o(to_wrap));

  assign in_row_o = IRW'(int'(row_o) * S_p + int'(i_o));
  assign in_col_o = ICW'(int'(col_o) * S_p + int'(j_o));

  // Flags are qualified by step_v_o so an idle scheduler drives all zeros.
  assign first_o = step_v_o && (ti_o == '0) && (i_o == '0) && (j_o == '0);
  assign last_o  = step_v_o && (ti_o == TI_LAST) && (i_o == K_LAST) && (j_o == K_LAST);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      step_v_o <= 1'b0;
    end else if (abort_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      step_v_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state    <= RUN;
            busy_o   <= 1'b1;
            step_v_o <= 1'b1;
          end
        end
        RUN: begin
          // Wrap of the outermost counter is the handshake of the final step.
          if (to_wrap) begin
            state    <= DONE;
            busy_o   <= 1'b0;
            step_v_o <= 1'b0;
            done_o   <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_o   <= 1'b0;
          done_o   <= 1'b0;
          step_v_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
